case_sel_driver: RTL and testbench
==================================

// Module: case_sel_driver
// PURPOSE
//  Clocked driver stage directly upstream of the 2-bit case decoder (sel,d -> a,b).
//  - Buffers (sel,d) commands, presents each to the decoder and holds it HOLD cycles.
//  - Samples the decoder's a/b, checks them against the decode rule and reports
//    one result per command over a valid/ready handshake.
// PARAMETERS
//  DEPTH     4   command FIFO entries (power of 2, >=2)
//  HOLD      2   cycles sel/d held before sampling a/b (>=1)
//  ERR_W     8   width of saturating mismatch counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      FIFO can accept; = !full
//  cmd_sel    in   2      select code to drive
//  cmd_d      in   1      data bit to drive
//  sel        out  2      registered select to decoder
//  d          out  1      registered data to decoder
//  a          in   1      decoder output a
//  b          in   1      decoder output b
//  res_valid  out  1      result held until res_ready
//  res_ready  in   1      downstream accepts result
//  res_sel    out  2      sel of the reported command
//  res_a      out  1      sampled a
//  res_b      out  1      sampled b
//  res_err    out  1      sampled {a,b} != expected
//  busy       out  1      state != IDLE or FIFO not empty
//  err_count  out  ERR_W  saturating count of res_err results
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO empty, state IDLE, sel=0, d=0, res_valid=0,
//   res_*=0, err_count=0, cmd_ready=1 once rst_n=1. Assertion mid-operation drops
//   the in-flight command and all queued commands; no result is emitted for them.
//  Push: cmd_valid && cmd_ready at an edge. cmd_ready depends only on full, so
//   there is no push when full, even with a simultaneous pop.
//  Expected rule: sel==0 -> {a,b}=01; sel==1 -> 10; sel>=2 -> a=d, b=d.
//   Any X/Z on a or b counts as a mismatch (=== compare).
//  FSM:
//   IDLE:   FIFO non-empty -> pop, load sel/d, cnt=HOLD-1, go DRIVE.
//   DRIVE:  cnt!=0 -> cnt--. cnt==0 -> capture a,b; set res_sel, res_err;
//           res_valid=1; err_count+=res_err (saturate at all-ones); go REPORT.
//   REPORT: res_valid held and res_* stable until res_ready. On handshake:
//           res_valid=0; if FIFO non-empty, pop and go DRIVE (back-to-back);
//           else go IDLE.
//  sel/d change only on a pop edge and otherwise hold the last driven value,
//   including in IDLE and REPORT.
//  Latency: command pushed at edge E0 into an empty IDLE block; popped at E1;
//   sampled at E1+HOLD; res_valid high after E1+HOLD.
//  Throughput with res_ready=1: one command per HOLD+1 cycles.
//  FIFO pointers are log2(DEPTH)+1 bits; they wrap modulo 2*DEPTH. full/empty
//   come from MSB/index compare. Simultaneous push+pop keeps occupancy unchanged.
// STRUCTURE
//  Package case_drv_pkg holds:
//   - state encoding localparams (IDLE=0, DRIVE=1, REPORT=2);
//   - expected-output function exp_ab(sel,d).
//  Sub-module case_drv_fifo (DEPTH x 3-bit {sel,d}, push/pop/full/empty).
//   The top holds the FSM, the hold counter, the result register and err_count.
// TESTING
//  1 Reset: rst_n=0 -> sel=0, d=0, res_valid=0, err_count=0, cmd_ready=1.
//  2 Cmds (0,0),(1,0),(2,0),(2,1) with the reference decoder attached ->
//    results {a,b}=01,10,00,11 in order, res_err=0, err_count=0.
//  3 Decoder stub forcing a=1 and cmd sel=0 -> res_err=1, err_count=1.
//    Repeat 300x -> err_count=255 and holds.
//  4 res_ready=0 with 5 cmds (DEPTH=4) -> 1 in flight + 4 queued, cmd_ready=0.
//    res_* stay stable. Release res_ready -> 5 results in order, 3-cycle spacing.
//  5 Drop rst_n while in DRIVE with 2 cmds queued -> no res_valid, FIFO empty.
//    After release, a new cmd gives a correct single result.
//  6 Push and pop on the same edge with the FIFO half full -> occupancy unchanged.
//    Run 20 cmds so pointers wrap -> order preserved.

Source files
------------

// File: rtl/case_drv_pkg.sv
// Shared definitions for the case-decoder driver stage.
//   state_t : driver FSM state encoding (IDLE=0, DRIVE=1, REPORT=2)
//   exp_ab  : expected decoder response {a,b} for a given (sel,d)
package case_drv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Decode rule: sel 0 -> 01, sel 1 -> 10, sel 2/3 -> both outputs follow d.
  function automatic logic [1:0] exp_ab(input logic [1:0] sel, input logic d);
    case (sel)
      2'd0:    return 2'b01;
      2'd1:    return 2'b10;
      default: return {d, d};
    endcase
  endfunction

endpackage

// File: rtl/case_drv_fifo.sv
// Command FIFO for the case-decoder driver.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata : write request/data, ignored when full
//   pop/rdata  : read request, ignored when empty; rdata shows the head entry
//   full/empty : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module case_drv_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         wr_en;
  logic         rd_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/case_sel_driver.sv
// Clocked driver stage feeding the 2-bit case decoder (sel,d -> a,b).
// Queues (sel,d) commands, drives each to the decoder for HOLD cycles, samples
// a/b, checks them against the decode rule and reports one result per command.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd_valid/ready     : command handshake (cmd_ready = FIFO not full)
//   cmd_sel, cmd_d      : command payload
//   sel, d              : registered drive to the decoder
//   a, b                : decoder outputs
//   res_valid/ready     : result handshake; res_* stable while res_valid
//   res_sel/a/b/err     : reported command select, sampled a/b, mismatch flag
//   busy                : FSM active or commands queued
//   err_count           : saturating count of mismatching results
module case_sel_driver
  import case_drv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 2,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_sel,
  input  logic             cmd_d,
  output logic [1:0]       sel,
  output logic             d,
  input  logic             a,
  input  logic             b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_sel,
  output logic             res_a,
  output logic             res_b,
  output logic             res_err,
  output logic             busy,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned       CNT_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             handshake;
  logic             mismatch;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign handshake = res_valid && res_ready;
  // A pop happens from IDLE, or on the result handshake for back-to-back issue.
  assign pop       = !fifo_empty && ((state == IDLE) || (state == REPORT && handshake));
  assign busy      = (state != IDLE) || !fifo_empty;
  // Case-equality so an X/Z on a or b is flagged as a mismatch in simulation.
  assign mismatch  = ({a, b} !== exp_ab(sel, d));

  case_drv_fifo #(
    .DEPTH (DEPTH),
    .W     (3)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({cmd_sel, cmd_d}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= '0;
      d         <= 1'b0;
      res_valid <= 1'b0;
      res_sel   <= '0;
      res_a     <= 1'b0;
      res_b     <= 1'b0;
      res_err   <= 1'b0;
      err_count <= '0;
    end else begin
      // sel/d only move on a pop; otherwise the last driven command is held.
      if (pop) begin
        sel <= fifo_rdata[2:1];
        d   <= fifo_rdata[0];
        cnt <= CNT_LOAD;
      end
      case (state)
        IDLE: begin
          if (pop) state <= DRIVE;
        end
        DRIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            res_sel   <= sel;
            res_a     <= a;
            res_b     <= b;
            res_err   <= mismatch;
            res_valid <= 1'b1;
            if (mismatch && (err_count != '1)) err_count <= err_count + 1'b1;
            state     <= REPORT;
          end
        end
        REPORT: begin
          if (handshake) begin
            res_valid <= 1'b0;
            state     <= pop ? DRIVE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_case_sel_driver.sv
// Directed testbench for case_sel_driver with a reference decoder attached.
module tb_case_sel_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_sel = 2'd0;
  logic       cmd_d = 1'b0;
  logic [1:0] sel;
  logic       d;
  logic       a;
  logic       b;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [1:0] res_sel;
  logic       res_a;
  logic       res_b;
  logic       res_err;
  logic       busy;
  logic [7:0] err_count;
  logic       stub = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Reference decoder; stub mode forces a high to provoke mismatches.
  assign a = stub ? 1'b1 : ((sel == 2'd0) ? 1'b0 : ((sel == 2'd1) ? 1'b1 : d));
  assign b = (sel == 2'd0) ? 1'b1 : ((sel == 2'd1) ? 1'b0 : d);

  case_sel_driver #(
    .DEPTH (4),
    .HOLD  (2),
    .ERR_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sel   (cmd_sel),
    .cmd_d     (cmd_d),
    .sel       (sel),
    .d         (d),
    .a         (a),
    .b         (b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sel   (res_sel),
    .res_a     (res_a),
    .res_b     (res_b),
    .res_err   (res_err),
    .busy      (busy),
    .err_count (err_count)
  );

  function automatic logic [1:0] model_ab(input logic [1:0] s, input logic dd);
    if (s == 2'd0) return 2'b01;
    if (s == 2'd1) return 2'b10;
    return {dd, dd};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic push_cmd(input logic [1:0] s, input logic dd);
    int t;
    t = 0;
    cmd_sel   = s;
    cmd_d     = dd;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("push_timeout", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Waits for a result, checks it, then accepts it with a one-cycle res_ready.
  task automatic expect_result(input string tag, input logic [1:0] es,
                               input logic ea, input logic eb, input logic ee);
    int t;
    t = 0;
    while (!res_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_sel"}, res_sel, es);
    check({tag, "_a"}, res_a, ea);
    check({tag, "_b"}, res_b, eb);
    check({tag, "_err"}, res_err, ee);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] t4_sel [5];
    logic       t4_d   [5];
    logic [1:0] hold_sel;
    logic       hold_a, hold_b;
    int         gap;
    logic [1:0] s;
    logic       dd;
    logic [1:0] ab;

    t4_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    t4_d   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    // 1: reset state
    repeat (3) @(negedge clk);
    check("rst_sel", sel, 0);
    check("rst_d", d, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_sel", res_sel, 0);
    check("rst_res_err", res_err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);

    // 2: reference decoder, four commands
    push_cmd(2'd0, 1'b0);
    push_cmd(2'd1, 1'b0);
    push_cmd(2'd2, 1'b0);
    push_cmd(2'd2, 1'b1);
    expect_result("t2_r0", 2'd0, 1'b0, 1'b1, 1'b0);
    expect_result("t2_r1", 2'd1, 1'b1, 1'b0, 1'b0);
    expect_result("t2_r2", 2'd2, 1'b0, 1'b0, 1'b0);
    expect_result("t2_r3", 2'd2, 1'b1, 1'b1, 1'b0);
    check("t2_err_count", err_count, 0);

    // 3: stubbed decoder, mismatches and saturation
    stub = 1'b1;
    push_cmd(2'd0, 1'b0);
    expect_result("t3_first", 2'd0, 1'b1, 1'b1, 1'b1);
    check("t3_err_count_1", err_count, 1);
    for (int i = 1; i < 300; i++) begin
      push_cmd(2'd0, 1'b0);
      expect_result("t3_rep", 2'd0, 1'b1, 1'b1, 1'b1);
      if (i == 254) check("t3_err_count_255", err_count, 255);
    end
    check("t3_err_count_sat", err_count, 255);
    stub = 1'b0;

    // 4: backpressure, 1 in flight + 4 queued, then drain at full rate
    for (int i = 0; i < 5; i++) push_cmd(t4_sel[i], t4_d[i]);
    check("t4_cmd_ready_full", cmd_ready, 0);
    check("t4_busy", busy, 1);
    check("t4_res_valid", res_valid, 1);
    hold_sel = res_sel;
    hold_a   = res_a;
    hold_b   = res_b;
    repeat (5) @(negedge clk);
    check("t4_hold_valid", res_valid, 1);
    check("t4_hold_sel", res_sel, hold_sel);
    check("t4_hold_a", res_a, hold_a);
    check("t4_hold_b", res_b, hold_b);
    check("t4_still_full", cmd_ready, 0);
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(negedge clk);
        gap = 1;
        while (!res_valid && gap < 20) begin
          @(negedge clk);
          gap++;
        end
        check("t4_gap", gap, 3);
      end
      ab = model_ab(t4_sel[k], t4_d[k]);
      check("t4_valid", res_valid, 1);
      check("t4_sel", res_sel, t4_sel[k]);
      check("t4_a", res_a, ab[1]);
      check("t4_b", res_b, ab[0]);
      check("t4_err", res_err, 0);
    end
    @(negedge clk);
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_idle_busy", busy, 0);
    check("t4_idle_ready", cmd_ready, 1);
    check("t4_err_count_held", err_count, 255);

    // 5: reset during DRIVE with two queued commands
    push_cmd(2'd1, 1'b0);
    push_cmd(2'd2, 1'b1);
    push_cmd(2'd3, 1'b0);
    check("t5_pre_busy", busy, 1);
    check("t5_pre_valid", res_valid, 0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", res_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_sel", sel, 0);
    check("t5_rst_err_count", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_post_valid", res_valid, 0);
    check("t5_post_busy", busy, 0);
    check("t5_post_ready", cmd_ready, 1);
    push_cmd(2'd1, 1'b1);
    expect_result("t5_new", 2'd1, 1'b1, 1'b0, 1'b0);
    check("t5_done_busy", busy, 0);

    // 6: push and pop on the same edge at half occupancy
    push_cmd(2'd0, 1'b0);
    push_cmd(2'd1, 1'b0);
    push_cmd(2'd2, 1'b1);
    gap = 0;
    while (!res_valid && gap < 50) begin
      @(negedge clk);
      gap++;
    end
    check("t6_first_valid", res_valid, 1);
    check("t6_first_sel", res_sel, 0);
    res_ready = 1'b1;
    cmd_sel   = 2'd3;
    cmd_d     = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    check("t6_after_both_ready", cmd_ready, 1);
    push_cmd(2'd0, 1'b1);
    check("t6_occ3_ready", cmd_ready, 1);
    push_cmd(2'd1, 1'b1);
    check("t6_occ4_ready", cmd_ready, 0);
    expect_result("t6_r1", 2'd1, 1'b1, 1'b0, 1'b0);
    expect_result("t6_r2", 2'd2, 1'b1, 1'b1, 1'b0);
    expect_result("t6_r3", 2'd3, 1'b1, 1'b1, 1'b0);
    expect_result("t6_r4", 2'd0, 1'b0, 1'b1, 1'b0);
    expect_result("t6_r5", 2'd1, 1'b1, 1'b0, 1'b0);

    // 6b: 20 commands so the pointers wrap several times
    for (int bt = 0; bt < 5; bt++) begin
      for (int j = 0; j < 4; j++) begin
        s  = 2'((bt * 4 + j) % 4);
        dd = 1'((bt + j) % 2);
        push_cmd(s, dd);
      end
      for (int j = 0; j < 4; j++) begin
        s  = 2'((bt * 4 + j) % 4);
        dd = 1'((bt + j) % 2);
        ab = model_ab(s, dd);
        expect_result("t6_wrap", s, ab[1], ab[0], 1'b0);
      end
    end
    check("t6_final_err_count", err_count, 0);
    check("t6_final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
